// File: rtl/bar_scheduler.sv
// Barrier scheduler: counts bar.sync arrivals per block and releases completed blocks round-robin.
// Latency: completing arrival sets bar_pending on that edge; release_valid follows one edge later.
// Backpressure: the offer is held stable until release_ready; it is withdrawn only if the offered block goes inactive.
module bar_scheduler #(
    parameter int NUM_BLOCKS    = 4,
    parameter int BLOCKID_DEPTH = $clog2(NUM_BLOCKS),
    parameter int MAX_WARPS     = 8,
    parameter int WCNT_DEPTH    = $clog2(MAX_WARPS + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             arrive_valid,
    input  logic [BLOCKID_DEPTH-1:0]         arrive_block,
    input  logic [NUM_BLOCKS-1:0]            block_active,
    input  logic [NUM_BLOCKS*WCNT_DEPTH-1:0] block_warps,
    output logic                             release_valid,
    output logic [BLOCKID_DEPTH-1:0]         release_block,
    input  logic                             release_ready,
    output logic [NUM_BLOCKS-1:0]            bar_pending,
    output logic                             bar_error
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                   state;
    logic [BLOCKID_DEPTH-1:0] ptr;
    logic [WCNT_DEPTH-1:0]    count [NUM_BLOCKS];
    logic [WCNT_DEPTH-1:0]    warps [NUM_BLOCKS];

    logic [NUM_BLOCKS-1:0]    arr_sel;
    logic [NUM_BLOCKS-1:0]    arr_ok;
    logic                     arr_err;
    logic [NUM_BLOCKS-1:0]    req;
    logic                     found;
    logic [BLOCKID_DEPTH-1:0] sel;
    logic [BLOCKID_DEPTH-1:0] idx;
    logic                     rel_done;

    // An arrival whose ID matches no resident slot leaves arr_sel empty and is flagged as out of range.
    always_comb begin
        arr_sel = '0;
        arr_ok  = '0;
        arr_err = 1'b0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            warps[i]   = block_warps[i*WCNT_DEPTH +: WCNT_DEPTH];
            arr_sel[i] = arrive_valid && (32'(arrive_block) == i);
            if (arr_sel[i]) begin
                if (!block_active[i] || warps[i] == '0 || bar_pending[i])
                    arr_err = 1'b1;
                else
                    arr_ok[i] = 1'b1;
            end
        end
        if (arrive_valid && arr_sel == '0)
            arr_err = 1'b1;
    end

    // Scan downward so the last hit written is the first pending block at or after ptr.
    always_comb begin
        req   = bar_pending & block_active;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = NUM_BLOCKS - 1; k >= 0; k--) begin
            idx = BLOCKID_DEPTH'((32'(ptr) + 32'(k)) % NUM_BLOCKS);
            if (req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign rel_done = (state == OFFER) && release_ready && block_active[release_block];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++)
                count[i] <= '0;
            bar_pending <= '0;
            bar_error   <= 1'b0;
        end else begin
            if (arr_err)
                bar_error <= 1'b1;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                if (!block_active[i]) begin
                    count[i]       <= '0;
                    bar_pending[i] <= 1'b0;
                end else if (arr_ok[i]) begin
                    if (count[i] + WCNT_DEPTH'(1) == warps[i]) begin
                        count[i]       <= '0;
                        bar_pending[i] <= 1'b1;
                    end else begin
                        count[i] <= count[i] + WCNT_DEPTH'(1);
                    end
                end else if (rel_done && 32'(release_block) == i) begin
                    bar_pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            release_valid <= 1'b0;
            release_block <= '0;
            ptr           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        release_block <= sel;
                        release_valid <= 1'b1;
                        state         <= OFFER;
                    end
                end
                OFFER: begin
                    if (!block_active[release_block]) begin
                        release_valid <= 1'b0;
                        state         <= IDLE;
                    end else if (release_ready) begin
                        release_valid <= 1'b0;
                        state         <= IDLE;
                        ptr <= (32'(release_block) == NUM_BLOCKS - 1) ? '0
                                                                      : release_block + BLOCKID_DEPTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bar_scheduler.sv
// Bench for bar_scheduler: per-cycle vector table plus hand-written corner sequences;
// every accepted release is checked against a queue of expected block IDs.
module tb_bar_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arrive_valid;
    logic [1:0]  arrive_block;
    logic [3:0]  block_active;
    logic [15:0] block_warps;
    logic        release_valid;
    logic [1:0]  release_block;
    logic        release_ready;
    logic [3:0]  bar_pending;
    logic        bar_error;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    bar_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arrive_valid (arrive_valid),
        .arrive_block (arrive_block),
        .block_active (block_active),
        .block_warps  (block_warps),
        .release_valid(release_valid),
        .release_block(release_block),
        .release_ready(release_ready),
        .bar_pending  (bar_pending),
        .bar_error    (bar_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       av;
        logic [1:0] ab;
        logic       rr;
        logic [3:0] ep;
        logic       ev;
        logic [1:0] eb;
        logic       ee;
        int         push;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic av, input logic [1:0] ab, input logic rr,
                                input logic [3:0] ep, input logic ev, input logic [1:0] eb,
                                input logic ee, input int push);
        vec_t v;
        v.rst = rst; v.av = av; v.ab = ab; v.rr = rr;
        v.ep = ep; v.ev = ev; v.eb = eb; v.ee = ee; v.push = push;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; reset is released well before the next edge.
    task automatic do_reset();
        arrive_valid  = 1'b0;
        arrive_block  = 2'd0;
        release_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic cyc(input logic av, input logic [1:0] ab, input logic rr);
        arrive_valid  = av;
        arrive_block  = ab;
        release_ready = rr;
        @(posedge clk);
        #1;
    endtask

    // Each accepted release must match the next expected block ID.
    always @(negedge clk) begin
        if (rst_n && release_valid && release_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rel_unexpected: released block %0d, none expected", release_block);
            end else begin
                check("rel_order", 32'(release_block), exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        arrive_valid  = 1'b0;
        arrive_block  = 2'd0;
        release_ready = 1'b0;
        block_active  = 4'b1111;
        block_warps   = {4'd2, 4'd3, 4'd2, 4'd3};

        @(posedge clk);
        #1;
        check("rst_valid", 32'(release_valid), 0);
        check("rst_block", 32'(release_block), 0);
        check("rst_pending", 32'(bar_pending), 0);
        check("rst_error", 32'(bar_error), 0);
        rst_n = 1'b1;

        // Single block of 3 warps, then blocks 0/1/3 completing back to back from ptr=0.
        tbl.push_back(mk(0, 1, 2, 1, 4'b0000, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 2, 1, 4'b0000, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 2, 1, 4'b0100, 0, 0, 0, -1));
        tbl.push_back(mk(0, 0, 0, 1, 4'b0100, 1, 2, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 4'b0000, 0, 2, 0, -1));
        tbl.push_back(mk(0, 0, 0, 1, 4'b0000, 0, 2, 0, -1));
        tbl.push_back(mk(1, 1, 0, 1, 4'b0000, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 0, 1, 4'b0000, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 1, 1, 4'b0000, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 3, 1, 4'b0000, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 0, 1, 4'b0001, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 1, 1, 4'b0011, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 4'b1010, 0, 0, 0, -1));
        tbl.push_back(mk(0, 0, 0, 1, 4'b1010, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 4'b1000, 0, 1, 0, -1));
        tbl.push_back(mk(0, 0, 0, 1, 4'b1000, 1, 3, 0, 3));
        tbl.push_back(mk(0, 0, 0, 1, 4'b0000, 0, 3, 0, -1));

        foreach (tbl[r]) begin
            if (tbl[r].rst) do_reset();
            if (tbl[r].push >= 0) exp_q.push_back(tbl[r].push);
            cyc(tbl[r].av, tbl[r].ab, tbl[r].rr);
            check($sformatf("vec%0d_pending", r), 32'(bar_pending), 32'(tbl[r].ep));
            check($sformatf("vec%0d_valid", r), 32'(release_valid), 32'(tbl[r].ev));
            check($sformatf("vec%0d_block", r), 32'(release_block), 32'(tbl[r].eb));
            check($sformatf("vec%0d_error", r), 32'(bar_error), 32'(tbl[r].ee));
        end

        // Stalled offer of block 1 stays put while 3 and 0 complete; then ptr=2 picks 3 before 0.
        do_reset();
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 3, 0);
        check("hold_first_valid", 32'(release_valid), 1);
        cyc(1, 3, 0);
        check("hold_valid_1", 32'(release_valid), 1);
        check("hold_block_1", 32'(release_block), 1);
        for (int i = 2; i <= 5; i++) begin
            if (i == 5) cyc(0, 0, 0); else cyc(1, 0, 0);
            check($sformatf("hold_valid_%0d", i), 32'(release_valid), 1);
            check($sformatf("hold_block_%0d", i), 32'(release_block), 1);
        end
        check("hold_pending", 32'(bar_pending), 32'b1011);
        exp_q.push_back(1);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1);
        check("hold_drain_pending", 32'(bar_pending), 0);
        check("hold_drain_valid", 32'(release_valid), 0);

        // Arrival to a pending block is an error and leaves its counter alone.
        do_reset();
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("err_none_yet", 32'(bar_error), 0);
        cyc(1, 0, 0);
        check("err_pending_arrival", 32'(bar_error), 1);
        check("err_pending_kept", 32'(bar_pending), 32'b0001);
        exp_q.push_back(0);
        cyc(0, 0, 1);
        check("err_released", 32'(bar_pending), 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        check("err_count_two", 32'(bar_pending), 0);
        cyc(1, 0, 0);
        check("err_count_three", 32'(bar_pending), 32'b0001);
        check("err_sticky", 32'(bar_error), 1);
        do_reset();
        check("err_reset_clear", 32'(bar_error), 0);
        block_active = 4'b1011;
        cyc(1, 2, 0);
        check("err_inactive", 32'(bar_error), 1);
        check("err_inactive_pending", 32'(bar_pending), 0);
        block_active = 4'b1111;
        do_reset();
        block_warps = {4'd2, 4'd0, 4'd2, 4'd3};
        cyc(1, 2, 0);
        check("err_zero_warps", 32'(bar_error), 1);
        block_warps = {4'd2, 4'd3, 4'd2, 4'd3};

        // Offered block goes inactive: offer withdrawn, FSM free to offer another block.
        do_reset();
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        check("deact_offer", 32'(release_valid), 1);
        block_active = 4'b1101;
        cyc(0, 0, 0);
        check("deact_valid", 32'(release_valid), 0);
        check("deact_pending", 32'(bar_pending), 0);
        block_active = 4'b1111;
        cyc(1, 3, 0);
        cyc(1, 3, 0);
        check("deact_next_pending", 32'(bar_pending), 32'b1000);
        cyc(0, 0, 0);
        check("deact_next_valid", 32'(release_valid), 1);
        check("deact_next_block", 32'(release_block), 3);
        exp_q.push_back(3);
        cyc(0, 0, 1);

        // Asynchronous reset between edges while an offer is outstanding.
        do_reset();
        cyc(1, 2, 0);
        cyc(1, 2, 0);
        cyc(1, 2, 0);
        cyc(0, 0, 0);
        check("arst_offer", 32'(release_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(release_valid), 0);
        check("arst_pending", 32'(bar_pending), 0);
        check("arst_block", 32'(release_block), 0);
        #2;
        rst_n = 1'b1;
        cyc(0, 0, 0);
        check("arst_after_valid", 32'(release_valid), 0);
        check("arst_after_pending", 32'(bar_pending), 0);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
